// File: rtl/riscv_pipe_pkg.sv
// Shared constants for the 5-stage RISC-V pipeline: control-bundle layout and the NOP bundle.
package riscv_pipe_pkg;

  localparam int unsigned CTRL_W = 11;
  localparam int unsigned REG_W  = 5;

  // Bit positions inside the packed control bundle
  localparam int unsigned CTRL_REG_WRITE  = 10;
  localparam int unsigned CTRL_MEM_READ   = 9;
  localparam int unsigned CTRL_MEM_WRITE  = 8;
  localparam int unsigned CTRL_MEM_TO_REG = 7;
  localparam int unsigned CTRL_ALU_SRC    = 6;
  localparam int unsigned CTRL_BRANCH     = 5;
  localparam int unsigned CTRL_JUMP       = 4;
  localparam int unsigned CTRL_ALU_OP_LSB = 0;
  localparam int unsigned CTRL_ALU_OP_W   = 4;

  localparam logic [CTRL_W-1:0] CTRL_NOP = '0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard equation: a load in EX whose rd is read by the instruction in ID.
module load_use_detect
  import riscv_pipe_pkg::*;
(
  input  logic             i_id_valid,
  input  logic [REG_W-1:0] i_id_rs1,
  input  logic [REG_W-1:0] i_id_rs2,
  input  logic             i_id_use_rs1,
  input  logic             i_id_use_rs2,
  input  logic             i_ex_valid,
  input  logic             i_ex_mem_read,
  input  logic [REG_W-1:0] i_ex_rd,
  output logic             o_hazard
);

  logic w_rs1_match;
  logic w_rs2_match;

  assign w_rs1_match = i_id_use_rs1 && (i_id_rs1 == i_ex_rd);
  assign w_rs2_match = i_id_use_rs2 && (i_id_rs2 == i_ex_rd);

  // x0 is never a real dependency
  assign o_hazard = i_id_valid && i_ex_valid && i_ex_mem_read && (i_ex_rd != '0) &&
                    (w_rs1_match || w_rs2_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush bubble, global hold and saturating
// stall/flush event counters.
module id_ex_stage
  import riscv_pipe_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [REG_W-1:0]  id_rs1,
  input  logic [REG_W-1:0]  id_rs2,
  input  logic [REG_W-1:0]  id_rd,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              ex_flush,
  input  logic              hold,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              load_use_stall,
  output logic              id_ex_valid,
  output logic [XLEN-1:0]   id_ex_pc,
  output logic [XLEN-1:0]   id_ex_rs1_data,
  output logic [XLEN-1:0]   id_ex_rs2_data,
  output logic [XLEN-1:0]   id_ex_imm,
  output logic [REG_W-1:0]  id_ex_rs1,
  output logic [REG_W-1:0]  id_ex_rs2,
  output logic [REG_W-1:0]  id_ex_rd,
  output logic [CTRL_W-1:0] id_ex_ctrl,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic              r_valid;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_rs1_data;
  logic [XLEN-1:0]   r_rs2_data;
  logic [XLEN-1:0]   r_imm;
  logic [REG_W-1:0]  r_rs1;
  logic [REG_W-1:0]  r_rs2;
  logic [REG_W-1:0]  r_rd;
  logic [CTRL_W-1:0] r_ctrl;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  logic              w_hazard;
  logic              w_stall;
  logic [CNT_W-1:0]  w_stall_cnt_inc;
  logic [CNT_W-1:0]  w_flush_cnt_inc;

  load_use_detect u_load_use_detect (
    .i_id_valid    (id_valid),
    .i_id_rs1      (id_rs1),
    .i_id_rs2      (id_rs2),
    .i_id_use_rs1  (id_use_rs1),
    .i_id_use_rs2  (id_use_rs2),
    .i_ex_valid    (r_valid),
    .i_ex_mem_read (r_ctrl[CTRL_MEM_READ]),
    .i_ex_rd       (r_rd),
    .o_hazard      (w_hazard)
  );

  // A flush squashes the ID instruction anyway, so it must not also stall the redirect
  assign w_stall     = w_hazard && !ex_flush && !rst;
  assign pc_write    = !rst && !hold && !w_stall;
  assign if_id_write = !rst && !hold && !w_stall;

  always_comb begin
    w_stall_cnt_inc = (&r_stall_cnt) ? r_stall_cnt : r_stall_cnt + CNT_W'(1);
    w_flush_cnt_inc = (&r_flush_cnt) ? r_flush_cnt : r_flush_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst || (!hold && (ex_flush || w_stall))) begin
      r_valid    <= 1'b0;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_ctrl     <= CTRL_NOP;
    end else if (!hold) begin
      r_valid    <= id_valid;
      r_pc       <= id_pc;
      r_rs1_data <= id_rs1_data;
      r_rs2_data <= id_rs2_data;
      r_imm      <= id_imm;
      r_rs1      <= id_rs1;
      r_rs2      <= id_rs2;
      r_rd       <= id_rd;
      r_ctrl     <= id_ctrl;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (!hold) begin
      if (ex_flush) begin
        r_flush_cnt <= w_flush_cnt_inc;
      end else if (w_stall) begin
        r_stall_cnt <= w_stall_cnt_inc;
      end
    end
  end

  assign load_use_stall = w_stall;
  assign id_ex_valid    = r_valid;
  assign id_ex_pc       = r_pc;
  assign id_ex_rs1_data = r_rs1_data;
  assign id_ex_rs2_data = r_rs2_data;
  assign id_ex_imm      = r_imm;
  assign id_ex_rs1      = r_rs1;
  assign id_ex_rs2      = r_rs2;
  assign id_ex_rd       = r_rd;
  assign id_ex_ctrl     = r_ctrl;
  assign stall_cnt      = r_stall_cnt;
  assign flush_cnt      = r_flush_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed hazard/flush/hold/reset cases plus a random tail.
module tb_id_ex_stage;
  import riscv_pipe_pkg::*;

  localparam logic [CTRL_W-1:0] LW_C  = 11'h6C0;  // reg_write, mem_read, mem_to_reg, alu_src
  localparam logic [CTRL_W-1:0] ADD_C = 11'h402;  // reg_write, alu_op=2

  logic              clk;
  logic              rst;
  logic              id_valid;
  logic [31:0]       id_pc;
  logic [31:0]       id_rs1_data;
  logic [31:0]       id_rs2_data;
  logic [31:0]       id_imm;
  logic [4:0]        id_rs1;
  logic [4:0]        id_rs2;
  logic [4:0]        id_rd;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [CTRL_W-1:0] id_ctrl;
  logic              ex_flush;
  logic              hold;
  logic              pc_write;
  logic              if_id_write;
  logic              load_use_stall;
  logic              id_ex_valid;
  logic [31:0]       id_ex_pc;
  logic [31:0]       id_ex_rs1_data;
  logic [31:0]       id_ex_rs2_data;
  logic [31:0]       id_ex_imm;
  logic [4:0]        id_ex_rs1;
  logic [4:0]        id_ex_rs2;
  logic [4:0]        id_ex_rd;
  logic [CTRL_W-1:0] id_ex_ctrl;
  logic [15:0]       stall_cnt;
  logic [15:0]       flush_cnt;

  typedef struct packed {
    logic              valid;
    logic [31:0]       pc;
    logic [31:0]       rs1d;
    logic [31:0]       rs2d;
    logic [31:0]       imm;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [CTRL_W-1:0] ctrl;
    logic [15:0]       sc;
    logic [15:0]       fc;
  } st_t;

  st_t m;
  st_t sb[$];
  int  n_total;
  int  n_bad;

  id_ex_stage dut (
    .clk            (clk),
    .rst            (rst),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_rs1_data    (id_rs1_data),
    .id_rs2_data    (id_rs2_data),
    .id_imm         (id_imm),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_rd          (id_rd),
    .id_use_rs1     (id_use_rs1),
    .id_use_rs2     (id_use_rs2),
    .id_ctrl        (id_ctrl),
    .ex_flush       (ex_flush),
    .hold           (hold),
    .pc_write       (pc_write),
    .if_id_write    (if_id_write),
    .load_use_stall (load_use_stall),
    .id_ex_valid    (id_ex_valid),
    .id_ex_pc       (id_ex_pc),
    .id_ex_rs1_data (id_ex_rs1_data),
    .id_ex_rs2_data (id_ex_rs2_data),
    .id_ex_imm      (id_ex_imm),
    .id_ex_rs1      (id_ex_rs1),
    .id_ex_rs2      (id_ex_rs2),
    .id_ex_rd       (id_ex_rd),
    .id_ex_ctrl     (id_ex_ctrl),
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic u1, input logic u2,
                        input logic [CTRL_W-1:0] c, input logic [31:0] pc);
    id_valid    = v;
    id_rs1      = rs1;
    id_rs2      = rs2;
    id_rd       = rd;
    id_use_rs1  = u1;
    id_use_rs2  = u2;
    id_ctrl     = c;
    id_pc       = pc;
    id_rs1_data = pc ^ 32'hA5A5_0000;
    id_rs2_data = pc + 32'd7;
    id_imm      = ~pc;
  endtask

  // Checks combinational outputs, predicts the next edge, then compares registered outputs
  task automatic step(input string tag);
    st_t  e;
    logic hz;
    logic stl;
    logic pw;
    #1;
    hz  = id_valid && m.valid && m.ctrl[CTRL_MEM_READ] && (m.rd != 5'd0) &&
          ((id_use_rs1 && id_rs1 == m.rd) || (id_use_rs2 && id_rs2 == m.rd));
    stl = hz && !ex_flush && !rst;
    pw  = !rst && !hold && !stl;
    check({tag, "_stall"}, {31'd0, load_use_stall}, {31'd0, stl});
    check({tag, "_pcw"}, {31'd0, pc_write}, {31'd0, pw});
    check({tag, "_ifidw"}, {31'd0, if_id_write}, {31'd0, pw});
    e = m;
    if (rst) begin
      e = '0;
    end else if (!hold) begin
      if (ex_flush || stl) begin
        e      = '0;
        e.sc   = m.sc;
        e.fc   = m.fc;
        if (ex_flush) e.fc = (m.fc == 16'hFFFF) ? m.fc : m.fc + 16'd1;
        else          e.sc = (m.sc == 16'hFFFF) ? m.sc : m.sc + 16'd1;
      end else begin
        e.valid = id_valid;
        e.pc    = id_pc;
        e.rs1d  = id_rs1_data;
        e.rs2d  = id_rs2_data;
        e.imm   = id_imm;
        e.rs1   = id_rs1;
        e.rs2   = id_rs2;
        e.rd    = id_rd;
        e.ctrl  = id_ctrl;
      end
    end
    m = e;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_valid"}, {31'd0, id_ex_valid}, {31'd0, e.valid});
      check({tag, "_pc"}, id_ex_pc, e.pc);
      check({tag, "_rs1d"}, id_ex_rs1_data, e.rs1d);
      check({tag, "_rs2d"}, id_ex_rs2_data, e.rs2d);
      check({tag, "_imm"}, id_ex_imm, e.imm);
      check({tag, "_idx"}, {17'd0, id_ex_rs1, id_ex_rs2, id_ex_rd}, {17'd0, e.rs1, e.rs2, e.rd});
      check({tag, "_ctrl"}, {21'd0, id_ex_ctrl}, {21'd0, e.ctrl});
      check({tag, "_scnt"}, {16'd0, stall_cnt}, {16'd0, e.sc});
      check({tag, "_fcnt"}, {16'd0, flush_cnt}, {16'd0, e.fc});
    end
  endtask

  initial begin
    n_total  = 0;
    n_bad    = 0;
    m        = '0;
    rst      = 1'b1;
    ex_flush = 1'b0;
    hold     = 1'b0;
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, CTRL_NOP, 32'h0);
    @(posedge clk);
    #1;

    // Reset state
    step("rst");
    check("rst_valid", {31'd0, id_ex_valid}, 32'd0);
    rst = 1'b0;

    // 1: load-use on rs1 stalls once, then the consumer loads
    set_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, LW_C, 32'h100);
    step("t1_lw");
    set_id(1'b1, 5'd5, 5'd3, 5'd6, 1'b1, 1'b1, ADD_C, 32'h104);
    #1;
    check("t1_stall_now", {31'd0, load_use_stall}, 32'd1);
    check("t1_pcw_now", {31'd0, pc_write}, 32'd0);
    step("t1_dep");
    check("t1_bubble", {31'd0, id_ex_valid}, 32'd0);
    check("t1_scnt", {16'd0, stall_cnt}, 32'd1);
    step("t1_go");
    check("t1_loaded_pc", id_ex_pc, 32'h104);

    // 2: rd=0 load, and unused rs2 match, never stall
    set_id(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0, LW_C, 32'h200);
    step("t2_lw0");
    set_id(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, ADD_C, 32'h204);
    step("t2_dep0");
    set_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, LW_C, 32'h208);
    step("t2_lw5");
    set_id(1'b1, 5'd3, 5'd5, 5'd8, 1'b1, 1'b0, ADD_C, 32'h20C);
    step("t2_norrs2");
    check("t2_loaded_pc", id_ex_pc, 32'h20C);

    // 3: flush wins over hazard
    set_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, LW_C, 32'h300);
    step("t3_lw");
    set_id(1'b1, 5'd5, 5'd3, 5'd6, 1'b1, 1'b1, ADD_C, 32'h304);
    ex_flush = 1'b1;
    step("t3_flush");
    ex_flush = 1'b0;
    check("t3_fcnt", {16'd0, flush_cnt}, 32'd1);

    // 4: hold freezes a pending hazard, then one bubble on release
    set_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, LW_C, 32'h400);
    step("t4_lw");
    set_id(1'b1, 5'd5, 5'd3, 5'd6, 1'b1, 1'b1, ADD_C, 32'h404);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) step("t4_hold");
    check("t4_held_pc", id_ex_pc, 32'h400);
    hold = 1'b0;
    step("t4_release");
    step("t4_go");

    // 5: stall counter saturates
    force dut.r_stall_cnt = 16'hFFFE;
    #1;
    release dut.r_stall_cnt;
    m.sc = 16'hFFFE;
    for (int i = 0; i < 3; i++) begin
      set_id(1'b1, 5'd1, 5'd2, 5'd9, 1'b1, 1'b0, LW_C, 32'h500 + 32'(i * 8));
      step("t5_lw");
      set_id(1'b1, 5'd2, 5'd9, 5'd4, 1'b0, 1'b1, ADD_C, 32'h504 + 32'(i * 8));
      step("t5_dep");
    end
    check("t5_sat", {16'd0, stall_cnt}, 32'h0000_FFFF);

    // 6: reset during an active stall leaves a clean pipe
    set_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, LW_C, 32'h600);
    step("t6_lw");
    set_id(1'b1, 5'd5, 5'd3, 5'd6, 1'b1, 1'b1, ADD_C, 32'h604);
    rst = 1'b1;
    step("t6_rst");
    rst = 1'b0;
    step("t6_first");
    check("t6_first_valid", {31'd0, id_ex_valid}, 32'd1);
    check("t6_scnt", {16'd0, stall_cnt}, 32'd0);

    // Random tail
    for (int i = 0; i < 80; i++) begin
      set_id(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 1) != 0) ? LW_C : ADD_C, $urandom);
      ex_flush = ($urandom_range(0, 7) == 0);
      hold     = ($urandom_range(0, 7) == 0);
      rst      = ($urandom_range(0, 29) == 0);
      step("rnd");
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
